// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic controller sensor path.
//   - Country-light encodings carried on CT_LIGHT (3 is treated as red).
//   - ct_state_t: sensor-unit FSM states.
//   - Default parameter values for ct_sensor_unit / loop_debounce.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SERVE = 2'd2
    } ct_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_PASS_CYCLES     = 3;
    localparam int unsigned DEF_QUEUE_W         = 4;

endpackage

// File: rtl/loop_debounce.sv
// loop_debounce: two-flop synchronizer plus debounce filter for the raw
// inductive-loop level. Emits a one-cycle arrival pulse on the edge where
// the debounced level rises.
//   clk_i       in   system clock, rising edge
//   rst_ni      in   synchronous active-low reset
//   loop_raw_i  in   asynchronous raw loop level (1 = vehicle over loop)
//   arrival_o   out  high during the cycle whose closing edge accepts a 0->1 level
module loop_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic loop_raw_i,
    output logic arrival_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch;
    logic             accept;

    assign mismatch = sync_q ^ deb_q;
    // The edge that finishes the persistence window both accepts the new
    // level and (for a rising level) signals the arrival to the queue.
    assign accept    = mismatch && (cnt_q == CNT_LAST);
    assign arrival_o = accept && sync_q;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (accept) begin
            deb_d = sync_q;
        end else if (mismatch) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= loop_raw_i;
            sync_q <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ct_sensor_unit.sv
// ct_sensor_unit: country-road vehicle sensor conditioner. Debounces the
// loop detector, counts waiting vehicles, releases one vehicle per
// PASS_CYCLES green cycles and raises CT_SENSOR while any vehicle waits.
//   CLOCK        in   system clock, rising edge
//   RESET        in   synchronous active-low reset
//   LOOP_RAW     in   asynchronous raw loop level
//   CT_LIGHT     in   country light (RED=0, YELLOW=1, GREEN=2, 3=RED)
//   CT_SENSOR    out  registered, high iff QUEUE_COUNT != 0
//   QUEUE_COUNT  out  registered number of waiting vehicles
//   OVERFLOW     out  sticky, set by an arrival at full count
// Build option: CT_YELLOW_PASS_EN lets vehicles depart on yellow as well.
module ct_sensor_unit
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PASS_CYCLES     = DEF_PASS_CYCLES,
    parameter int unsigned QUEUE_W         = DEF_QUEUE_W
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               LOOP_RAW,
    input  logic [1:0]         CT_LIGHT,
    output logic               CT_SENSOR,
    output logic [QUEUE_W-1:0] QUEUE_COUNT,
    output logic               OVERFLOW
);

    localparam int unsigned TMR_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PASS_CYCLES - 1);

    ct_state_t          state_q, state_d;
    logic [QUEUE_W-1:0] queue_q, queue_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sensor_q, sensor_d;
    logic               ovf_q, ovf_d;
    logic               arrival;
    logic               departure;
    logic               pass_light;
    logic               timer_en;

    loop_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i      (CLOCK),
        .rst_ni     (RESET),
        .loop_raw_i (LOOP_RAW),
        .arrival_o  (arrival)
    );

`ifdef CT_YELLOW_PASS_EN
    assign pass_light = (CT_LIGHT == LIGHT_GREEN) || (CT_LIGHT == LIGHT_YELLOW);
`else
    assign pass_light = (CT_LIGHT == LIGHT_GREEN);
`endif

    assign departure = timer_en && (timer_q == TMR_LAST);
    assign timer_d   = (timer_en && !departure) ? timer_q + 1'b1 : '0;

    always_comb begin
        queue_d = queue_q;
        ovf_d   = ovf_q;
        if (arrival && !departure) begin
            if (&queue_q) begin
                ovf_d = 1'b1;
            end else begin
                queue_d = queue_q + 1'b1;
            end
        end else if (departure && !arrival) begin
            queue_d = queue_q - 1'b1;
        end
    end

    // The state follows the next queue value, so state_q != IDLE exactly
    // when queue_q != 0; the timer enable can therefore be taken from the
    // state without an extra cycle of latency.
    always_comb begin
        state_d  = state_q;
        timer_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (queue_d != '0) state_d = WAIT;
            end
            WAIT: begin
                timer_en = pass_light;
                if (queue_d == '0)   state_d = IDLE;
                else if (pass_light) state_d = SERVE;
            end
            SERVE: begin
                timer_en = pass_light;
                if (queue_d == '0)    state_d = IDLE;
                else if (!pass_light) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
        sensor_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q  <= IDLE;
            queue_q  <= '0;
            timer_q  <= '0;
            sensor_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            queue_q  <= queue_d;
            timer_q  <= timer_d;
            sensor_q <= sensor_d;
            ovf_q    <= ovf_d;
        end
    end

    assign CT_SENSOR   = sensor_q;
    assign QUEUE_COUNT = queue_q;
    assign OVERFLOW    = ovf_q;

endmodule
